// File: rtl/result_unloader_if.sv
// result_unloader_if: start/memory-port/stream bundle between the drain stage and its surroundings
interface result_unloader_if #(
  parameter int WIDTH = 16
);
  logic             start_i;
  logic [WIDTH-1:0] mem_rdata_i;
  logic [WIDTH-1:0] mem_addr_o;
  logic             mem_rd_en_o;
  logic [WIDTH-1:0] out_data_o;
  logic             out_valid_o;
  logic             out_ready_i;
  logic             out_last_o;
  logic             busy_o;
  logic             done_o;
  modport master (
    input  start_i, mem_rdata_i, out_ready_i,
    output mem_addr_o, mem_rd_en_o, out_data_o, out_valid_o, out_last_o, busy_o, done_o
  );
  modport slave (
    output start_i, mem_rdata_i, out_ready_i,
    input  mem_addr_o, mem_rd_en_o, out_data_o, out_valid_o, out_last_o, busy_o, done_o
  );
endinterface

// File: rtl/result_unloader.sv
// result_unloader: drains a data_mem window word by word onto a valid/ready stream after a start edge
// Optional RESULT_UNLOADER_CHECKSUM_EN appends a mod-2^WIDTH sum word carrying out_last.
module result_unloader #(
  parameter int WIDTH     = 16,
  parameter int BASE_ADDR = 127,
  parameter int COUNT     = 128
) (
  input logic           clk,
  input logic           rst,
  result_unloader_if.master bus
);
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] REQ  = 3'd1;
  localparam logic [2:0] WAIT = 3'd2;
  localparam logic [2:0] SEND = 3'd3;
  localparam logic [2:0] DONE = 3'd4;
`ifdef RESULT_UNLOADER_CHECKSUM_EN
  localparam logic [2:0] CSUM = 3'd5;
`endif
  localparam logic [WIDTH-1:0] BASE  = WIDTH'(BASE_ADDR);
  localparam logic [WIDTH-1:0] LAST  = WIDTH'(COUNT - 1);
  localparam bit               EMPTY = (COUNT == 0);

  logic [2:0]       state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d, addr_q, addr_d, data_q, data_d;
  logic             last_q, last_d, done_q, done_d;
  logic             start_q, arm_q, launch;
`ifdef RESULT_UNLOADER_CHECKSUM_EN
  logic [WIDTH-1:0] sum_q, sum_d;
`endif

  // arm_q blocks a start that is already high when reset releases
  assign launch = bus.start_i && !start_q && arm_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    last_d  = last_q;
    done_d  = done_q;
`ifdef RESULT_UNLOADER_CHECKSUM_EN
    sum_d   = sum_q;
`endif
    case (state_q)
      IDLE, DONE: if (launch) begin
        done_d = 1'b0;
        cnt_d  = '0;
`ifdef RESULT_UNLOADER_CHECKSUM_EN
        sum_d  = '0;
`endif
        if (EMPTY) begin
`ifdef RESULT_UNLOADER_CHECKSUM_EN
          state_d = CSUM;
`else
          state_d = DONE;
          done_d  = 1'b1;
`endif
        end else begin
          state_d = REQ;
          addr_d  = BASE;
        end
      end
      REQ: state_d = WAIT;
      WAIT: begin
        data_d  = bus.mem_rdata_i;
`ifdef RESULT_UNLOADER_CHECKSUM_EN
        last_d  = 1'b0;
        sum_d   = sum_q + bus.mem_rdata_i;
`else
        last_d  = (cnt_q == LAST);
`endif
        state_d = SEND;
      end
      SEND: if (bus.out_ready_i) begin
        if (last_q) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
`ifdef RESULT_UNLOADER_CHECKSUM_EN
        else if (cnt_q == LAST) state_d = CSUM;
`endif
        else begin
          cnt_d   = cnt_q + 1'b1;
          addr_d  = BASE + cnt_q + 1'b1;
          state_d = REQ;
        end
      end
`ifdef RESULT_UNLOADER_CHECKSUM_EN
      CSUM: begin
        data_d  = sum_q;
        last_d  = 1'b1;
        state_d = SEND;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      start_q <= 1'b0;
      arm_q   <= 1'b0;
`ifdef RESULT_UNLOADER_CHECKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      last_q  <= last_d;
      done_q  <= done_d;
      start_q <= bus.start_i;
      arm_q   <= arm_q | !bus.start_i;
`ifdef RESULT_UNLOADER_CHECKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  assign bus.mem_addr_o  = addr_q;
  assign bus.mem_rd_en_o = (state_q == REQ);
  assign bus.out_data_o  = data_q;
  assign bus.out_valid_o = (state_q == SEND);
  assign bus.out_last_o  = last_q;
  assign bus.busy_o      = (state_q != IDLE) && (state_q != DONE);
  assign bus.done_o      = done_q;
endmodule

// File: doc/result_unloader.md
Name: result_unloader

Overview:
- Downstream drain stage for the 8-core processor.
- Once the processor signals completion on its all-cores-done flag (wired to start), this block takes the data_mem read port through the external top-level mux. It reads the core result regions sequentially and streams each word out on a valid/ready interface toward the host link, e.g. a UART or PCIe shim.
- Default window covers all eight per-core result regions, addresses 127..254.

Parameters:
- WIDTH, 16, data and address width; matches the processor datapath.
- BASE_ADDR, 127, first data_mem address read.
- COUNT, 128, number of words read; range 0..2^WIDTH-1.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous reset, active high
- start  input  1  level from processor proc_state; rising edge launches a drain
- mem_rdata  input  WIDTH  data_mem read data; valid the cycle after mem_rd_en sampled high
- mem_addr  output  WIDTH  data_mem read address
- mem_rd_en  output  1  data_mem read enable, one-cycle pulse per word
- out_data  output  WIDTH  streamed word
- out_valid  output  1  out_data valid
- out_ready  input  1  sink accepts word when out_valid && out_ready
- out_last  output  1  high with the final word of a drain
- busy  output  1  high in any state except IDLE/DONE
- done  output  1  sticky; high from drain completion until next accepted start edge

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values: all outputs 0, state IDLE, start_q=0, word counter 0.
- Edge detect: start_q registers start each cycle. A start edge is start && !start_q. Edges are accepted only in IDLE or DONE and ignored otherwise.
- States: IDLE, REQ, WAIT, SEND, DONE.
- IDLE/DONE on edge:
  - If COUNT != 0: clear done, cnt=0, go REQ.
  - If COUNT == 0: go straight to DONE with done=1 and no words, unless CHECKSUM_EN is defined.
- REQ (one cycle): mem_rd_en=1, mem_addr=(BASE_ADDR+cnt) mod 2^WIDTH; go WAIT.
- WAIT (one cycle): mem_rd_en=0; out_data<=mem_rdata; out_last<=(cnt==COUNT-1); go SEND.
- SEND: out_valid=1.
  - out_data and out_last are held stable while out_ready=0.
  - On handshake: out_valid<=0. If out_last, go DONE with done=1; else cnt<=cnt+1, go REQ.
- Timing:
  - Edge sampled at cycle N.
  - mem_rd_en high in N+1.
  - First out_valid at N+3.
  - With out_ready tied high, one word every 3 cycles.
  - Total drain = 3*COUNT cycles from first REQ to DONE.
- mem_addr holds its last value outside REQ. mem_rd_en is never high outside REQ.
- Address wrap: BASE_ADDR+cnt wraps modulo 2^WIDTH, with no error.
- Counter is WIDTH bits. COUNT-1 compare covers the full range.
- Reset mid-drain: next cycle IDLE, all outputs 0, in-flight word discarded. A start already high at reset release does not launch a drain until it falls and rises again.
- start falling mid-drain: no effect.

Optional Feature:
- Macro: RESULT_UNLOADER_CHECKSUM_EN.
- Defined:
  - After the last data word, one extra word is sent: sum of all data words mod 2^WIDTH, accumulated at capture in WAIT.
  - out_last moves to the checksum word and is low on all data words.
  - A new state CSUM presents the checksum in one cycle after the last data handshake.
  - COUNT==0 emits a single word 0x0000 with out_last=1.
- Undefined: no checksum logic; behaviour exactly as above.

Test Plan:
- Basic drain:
  - Setup: BASE_ADDR=127, COUNT=4, mem[127..130]=0x0011,0x0022,0x0033,0x0044, out_ready=1, start 0->1.
  - Response: mem_rd_en pulses at N+1,N+4,N+7,N+10 with addresses 127..130. out_data 0x0011..0x0044. out_last only with 0x0044. done=1 and busy=0 at N+13.
- Backpressure:
  - Stimulus: as basic drain, but out_ready=0 for 5 cycles while the second word is presented.
  - Response: out_data=0x0022 and out_valid=1 held stable. No mem_rd_en during the stall. Sequence is unchanged.
- Wrap and edge rules:
  - Setup: BASE_ADDR=0xFFFE, COUNT=3.
  - Response: addresses 0xFFFE,0xFFFF,0x0000. start held high after DONE causes no relaunch. Toggling start 1->0->1 relaunches and clears done.
- Reset mid-drain:
  - Stimulus: rst asserted for 1 cycle during the second SEND.
  - Response: next cycle out_valid=0, busy=0, done=0, mem_rd_en=0. start high through reset gives no drain until a new edge.
- Ignored edge: a start pulse during busy produces no change to cnt or addresses.
- Checksum (RESULT_UNLOADER_CHECKSUM_EN defined), basic data:
  - Response: 5 words, the fifth 0x00AA with out_last. With COUNT=0, one word 0x0000 with out_last.
